// File: rtl/weight_bram_reader.sv
// weight_bram_reader: read-side responder for the dual-port weight BRAM.
// Tracks a base word address driven by control-unit commands, pulses both
// BRAM read ports for every accepted command, and flags data valid
// BRAM_LATENCY cycles after the enable pulse.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   address_reset            rewind base to 0 and refetch; also arms the block
//   bram_control_add1/add2   advance base by 1/2; honoured only while valid
//   bram_port_sel            0 selects port A data, 1 selects port B data
//   load_weight_preload      consumer took weight_data (statistics only)
//   bram_addra/addrb         port A = base, port B = base+1 (wrapping)
//   bram_ena/enb             one-cycle read enables
//   bram_douta/doutb         BRAM read data
//   weight_from_bram_valid   read data belongs to the current base address
//   weight_data              combinational port mux of the read data
//   addr_overflow            sticky: an add carried out of the base address
//   read_count               preload counter (optional feature)
//
// Optional feature macro: WEIGHT_READ_STAT_EN. When defined, read_count
// counts cycles with load_weight_preload and valid both high, saturating,
// and clears on rst or address_reset. When undefined it is tied to 0.

module weight_bram_reader #(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int WEIGHT_WIDTH       = 32,
  parameter int BRAM_LATENCY       = 2   // legal range 1..4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          address_reset,
  input  logic                          bram_control_add1,
  input  logic                          bram_control_add2,
  input  logic                          bram_port_sel,
  input  logic                          load_weight_preload,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addra,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addrb,
  output logic                          bram_ena,
  output logic                          bram_enb,
  input  logic [WEIGHT_WIDTH-1:0]       bram_douta,
  input  logic [WEIGHT_WIDTH-1:0]       bram_doutb,
  output logic                          weight_from_bram_valid,
  output logic [WEIGHT_WIDTH-1:0]       weight_data,
  output logic                          addr_overflow,
  output logic [31:0]                   read_count
);

  localparam int AW = BRAM_ADDRESS_WIDTH;
  localparam logic [2:0] LAT = BRAM_LATENCY[2:0];

  // UNPRIMED: no address_reset seen yet, adds ignored.
  // FETCH:    read issued, waiting out the BRAM latency.
  // READY:    read data valid for the current base.
  typedef enum logic [1:0] {
    S_UNPRIMED = 2'd0,
    S_FETCH    = 2'd1,
    S_READY    = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   base, base_nxt;
  logic            ovf_nxt;
  logic            issue;
  logic [2:0]      lat_cnt;
  logic            valid;
  logic [AW:0]     sum_ext;

  assign valid = (state == S_READY);

  // Carry-extended add: the top bit is the wrap out of the base address.
  assign sum_ext = {1'b0, base} +
                   {{(AW-1){1'b0}}, bram_control_add2, ~bram_control_add2};

  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    ovf_nxt   = addr_overflow;
    issue     = 1'b0;

    if (address_reset) begin
      base_nxt = '0;
      ovf_nxt  = 1'b0;
      issue    = 1'b1;
    end else if (valid && (bram_control_add1 || bram_control_add2)) begin
      // add2 wins when both adds are high (sum_ext already selects +2)
      base_nxt = sum_ext[AW-1:0];
      if (sum_ext[AW]) ovf_nxt = 1'b1;
      issue    = 1'b1;
    end

    if (issue) begin
      // Any accepted command restarts the fetch, discarding one in flight.
      state_nxt = S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (lat_cnt == 3'd1) state_nxt = S_READY;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_UNPRIMED;
      base          <= '0;
      addr_overflow <= 1'b0;
      bram_ena      <= 1'b0;
      bram_enb      <= 1'b0;
      lat_cnt       <= 3'd0;
    end else begin
      state         <= state_nxt;
      base          <= base_nxt;
      addr_overflow <= ovf_nxt;
      bram_ena      <= issue;
      bram_enb      <= issue;
      // Counter holds BRAM_LATENCY in the enable cycle and reaches 1 in the
      // last wait cycle, so valid rises BRAM_LATENCY cycles after the pulse.
      if (issue)
        lat_cnt <= LAT;
      else if (lat_cnt != 3'd0)
        lat_cnt <= lat_cnt - 3'd1;
    end
  end

  assign bram_addra             = base;
  assign bram_addrb             = base + {{(AW-1){1'b0}}, 1'b1};
  assign weight_from_bram_valid = valid;
  assign weight_data            = bram_port_sel ? bram_doutb : bram_douta;

`ifdef WEIGHT_READ_STAT_EN
  logic [31:0] rd_cnt;

  always_ff @(posedge clk) begin
    if (rst || address_reset)
      rd_cnt <= 32'd0;
    else if (load_weight_preload && valid && (rd_cnt != 32'hFFFF_FFFF))
      rd_cnt <= rd_cnt + 32'd1;
  end

  assign read_count = rd_cnt;
`else
  logic unused_preload;
  assign unused_preload = load_weight_preload;
  assign read_count     = 32'd0;
`endif

endmodule

// File: tb/tb_weight_bram_reader.sv
// Directed self-checking bench for weight_bram_reader at default parameters.
module tb_weight_bram_reader;

  localparam int AW = 12;
  localparam int WW = 32;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          address_reset = 1'b0;
  logic          bram_control_add1 = 1'b0;
  logic          bram_control_add2 = 1'b0;
  logic          bram_port_sel = 1'b0;
  logic          load_weight_preload = 1'b0;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic          bram_ena, bram_enb;
  logic [WW-1:0] bram_douta = 32'h0000_00A0;
  logic [WW-1:0] bram_doutb = 32'h0000_00B0;
  logic          weight_from_bram_valid;
  logic [WW-1:0] weight_data;
  logic          addr_overflow;
  logic [31:0]   read_count;

  int vectors = 0;
  int miscompares = 0;

  weight_bram_reader #(
    .BRAM_ADDRESS_WIDTH(AW),
    .WEIGHT_WIDTH(WW),
    .BRAM_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address_reset(address_reset),
    .bram_control_add1(bram_control_add1),
    .bram_control_add2(bram_control_add2),
    .bram_port_sel(bram_port_sel),
    .load_weight_preload(load_weight_preload),
    .bram_addra(bram_addra),
    .bram_addrb(bram_addrb),
    .bram_ena(bram_ena),
    .bram_enb(bram_enb),
    .bram_douta(bram_douta),
    .bram_doutb(bram_doutb),
    .weight_from_bram_valid(weight_from_bram_valid),
    .weight_data(weight_data),
    .addr_overflow(addr_overflow),
    .read_count(read_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse a command for one cycle, then wait out the fetch latency.
  task automatic cmd(input logic r, input logic a1, input logic a2);
    address_reset     = r;
    bram_control_add1 = a1;
    bram_control_add2 = a2;
    step();
    address_reset     = 1'b0;
    bram_control_add1 = 1'b0;
    bram_control_add2 = 1'b0;
    repeat (L) step();
  endtask

`ifdef WEIGHT_READ_STAT_EN
  localparam logic [31:0] EXP_CNT5 = 32'd5;
`else
  localparam logic [31:0] EXP_CNT5 = 32'd0;
`endif

  initial begin
    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_addra", bram_addra, 0);
    chk("rst_addrb", bram_addrb, 1);
    chk("rst_ena", bram_ena, 0);
    chk("rst_enb", bram_enb, 0);
    chk("rst_valid", weight_from_bram_valid, 0);
    chk("rst_ovf", addr_overflow, 0);
    chk("rst_cnt", read_count, 0);

    // add1 before priming is ignored
    bram_control_add1 = 1'b1;
    step();
    bram_control_add1 = 1'b0;
    chk("unprimed_addra", bram_addra, 0);
    chk("unprimed_ena", bram_ena, 0);
    chk("unprimed_valid", weight_from_bram_valid, 0);

    // address_reset: pulse next cycle, valid L cycles later
    address_reset = 1'b1;
    step();
    address_reset = 1'b0;
    chk("ar_ena", bram_ena, 1);
    chk("ar_enb", bram_enb, 1);
    chk("ar_addra", bram_addra, 0);
    chk("ar_addrb", bram_addrb, 1);
    chk("ar_valid_t1", weight_from_bram_valid, 0);
    // add2 during the wait is ignored; preload pulses here must not count
    bram_control_add2 = 1'b1;
    load_weight_preload = 1'b1;
    step();
    bram_control_add2 = 1'b0;
    chk("wait_add2_addra", bram_addra, 0);
    chk("wait_ena", bram_ena, 0);
    chk("wait_valid", weight_from_bram_valid, 0);
    step();
    load_weight_preload = 1'b0;
    chk("ar_valid_t3", weight_from_bram_valid, 1);
    chk("ar_addra_hold", bram_addra, 0);
    bram_port_sel = 1'b0;
    #1 chk("mux_a", weight_data, 32'h0000_00A0);
    bram_port_sel = 1'b1;
    #1 chk("mux_b", weight_data, 32'h0000_00B0);
    chk("mux_valid", weight_from_bram_valid, 1);
    chk("cnt_before", read_count, 0);

    // five preloads while valid
    load_weight_preload = 1'b1;
    repeat (5) step();
    load_weight_preload = 1'b0;
    chk("cnt_five", read_count, EXP_CNT5);

    // add1 with valid: addresses move, valid drops then returns
    bram_control_add1 = 1'b1;
    step();
    bram_control_add1 = 1'b0;
    chk("add1_ena", bram_ena, 1);
    chk("add1_addra", bram_addra, 1);
    chk("add1_addrb", bram_addrb, 2);
    chk("add1_valid_t1", weight_from_bram_valid, 0);
    step();
    chk("add1_valid_t2", weight_from_bram_valid, 0);
    step();
    chk("add1_valid_t3", weight_from_bram_valid, 1);
    chk("cnt_kept", read_count, EXP_CNT5);

    cmd(1'b0, 1'b0, 1'b1);
    chk("add2_addra", bram_addra, 3);
    chk("add2_addrb", bram_addrb, 4);
    chk("add2_valid", weight_from_bram_valid, 1);

    // walk to base 10, then add1+add2 together -> 12
    cmd(1'b0, 1'b0, 1'b1);
    cmd(1'b0, 1'b0, 1'b1);
    cmd(1'b0, 1'b0, 1'b1);
    cmd(1'b0, 1'b1, 1'b0);
    chk("base10", bram_addra, 10);
    cmd(1'b0, 1'b1, 1'b1);
    chk("both_add2_wins", bram_addra, 12);
    cmd(1'b1, 1'b0, 1'b1);
    chk("ar_beats_add2", bram_addra, 0);
    chk("ar_clears_cnt", read_count, 0);
    chk("ar_valid", weight_from_bram_valid, 1);

    // wrap: climb to 4094, then 4095 (addrb wraps, no flag), then 0 (flag)
    for (int i = 0; i < 2047; i++) cmd(1'b0, 1'b0, 1'b1);
    chk("base4094", bram_addra, 4094);
    cmd(1'b0, 1'b1, 1'b0);
    chk("base4095", bram_addra, 4095);
    chk("addrb_wrap", bram_addrb, 0);
    chk("addrb_wrap_noflag", addr_overflow, 0);
    bram_control_add1 = 1'b1;
    step();
    bram_control_add1 = 1'b0;
    chk("wrap_addra", bram_addra, 0);
    chk("wrap_addrb", bram_addrb, 1);
    chk("wrap_ovf", addr_overflow, 1);
    repeat (L) step();
    cmd(1'b0, 1'b0, 1'b1);
    chk("ovf_sticky_addra", bram_addra, 2);
    chk("ovf_sticky", addr_overflow, 1);
    cmd(1'b1, 1'b0, 1'b0);
    chk("ovf_cleared", addr_overflow, 0);

    // reset mid-fetch drops the fetch and requires re-priming
    cmd(1'b0, 1'b1, 1'b0);
    address_reset = 1'b1;
    step();
    address_reset = 1'b0;
    chk("midrst_ena_pre", bram_ena, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ena", bram_ena, 0);
    chk("midrst_valid", weight_from_bram_valid, 0);
    repeat (4) step();
    chk("midrst_valid_late", weight_from_bram_valid, 0);
    bram_control_add1 = 1'b1;
    step();
    bram_control_add1 = 1'b0;
    chk("midrst_add_ignored", bram_addra, 0);
    chk("midrst_no_ena", bram_ena, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/weight_bram_reader.md
Name: weight_bram_reader

Overview:
Read-side responder for the weight BRAM. It consumes the control unit's weight-fetch commands: address_reset, bram_control_add1, bram_control_add2 and bram_port_sel. It drives both BRAM read ports and returns weight_from_bram_valid with the selected weight word. It sits between the control unit and the dual-port weight BRAM, ahead of the MAC weight preload path.

Parameters:
BRAM_ADDRESS_WIDTH, 12, width of the BRAM word address.
WEIGHT_WIDTH, 32, width of one BRAM word / weight bundle.
BRAM_LATENCY, 2, cycles from port enable to valid dout; legal range 1..4.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
address_reset  input  1  rewind base address to 0 and refetch
bram_control_add1  input  1  advance base address by 1
bram_control_add2  input  1  advance base address by 2
bram_port_sel  input  1  0: output port A data, 1: output port B data
load_weight_preload  input  1  consumer took weight_data this cycle (statistics only)
bram_addra  output  BRAM_ADDRESS_WIDTH  port A address = base
bram_addrb  output  BRAM_ADDRESS_WIDTH  port B address = base+1 (mod 2^W)
bram_ena  output  1  port A read enable, one-cycle pulse
bram_enb  output  1  port B read enable, one-cycle pulse
bram_douta  input  WEIGHT_WIDTH  port A read data
bram_doutb  input  WEIGHT_WIDTH  port B read data
weight_from_bram_valid  output  1  douta/doutb correspond to current base address
weight_data  output  WEIGHT_WIDTH  bram_port_sel ? bram_doutb : bram_douta
addr_overflow  output  1  sticky: base address wrapped
read_count  output  32  preload count (see optional feature)

Behaviour:
- Reset (rst=1 at a clock edge) sets: base=0, bram_ena=bram_enb=0, valid=0, primed=0, latency counter=0, addr_overflow=0, read_count=0. bram_addra=0, bram_addrb=1.
- primed is set by the first address_reset. While primed=0, valid stays 0 and add requests are ignored.
- Accepted command in cycle T (priority order):
  1. address_reset: base<=0, addr_overflow<=0.
  2. add2: accepted only if valid=1; base<=base+2.
  3. add1: accepted only if valid=1; base<=base+1.
- add1 or add2 with valid=0 is ignored: no address change, no read issued.
- add1 and add2 both high: add2 wins.
- Issue rule: after an accepted command in T, valid drops at T+1. bram_ena/enb pulse high in T+1 with the new addresses. The latency counter loads BRAM_LATENCY at T+1. valid rises at T+1+BRAM_LATENCY.
- Valid holds high until the next accepted command. Addresses are stable while valid=1.
- A new accepted command while valid=0 (during the latency wait) restarts the issue. The old fetch is discarded and the counter reloads.
- Arithmetic is modulo 2^BRAM_ADDRESS_WIDTH. If an add carries out of base, set addr_overflow (sticky until address_reset or rst).
- bram_addrb wrapping from max to 0 does not set the flag.
- weight_data is a combinational mux; bram_port_sel has no effect on valid.
- Latency: command to valid = 1+BRAM_LATENCY cycles (3 at default).
- Reset mid-fetch: all state cleared, pending fetch dropped. The consumer must reissue address_reset.

Optional Feature:
WEIGHT_READ_STAT_EN:
- Defined: read_count increments by 1 on each cycle with load_weight_preload=1 and valid=1. It saturates at 32'hFFFFFFFF and clears on rst or address_reset.
- Undefined: counter logic removed; read_count tied to 0.

Test Plan:
1. rst, then address_reset in cycle 5 -> ena/enb pulse in cycle 6 with addra=0, addrb=1; valid=1 from cycle 8 (BRAM_LATENCY=2); weight_data follows port_sel (douta=0xA0, doutb=0xB0 observed correctly).
2. Valid=1 at base 0, add1 pulse -> valid low next cycle, addra=1, addrb=2, valid returns 3 cycles after command; then add2 -> addra=3, addrb=4.
3. add1 before any address_reset, and add2 while valid=0 -> addresses unchanged, no enable pulse, valid stays 0.
4. add1 and add2 both high with valid=1 at base 10 -> base=12. address_reset together with add2 -> base=0.
5. BRAM_ADDRESS_WIDTH=12, base=4095, valid=1, add1 -> base=0, addr_overflow=1; flag stays 1 across further adds; address_reset clears it.
6. With WEIGHT_READ_STAT_EN: 5 preload pulses while valid=1 and 2 pulses while valid=0 -> read_count=5; address_reset -> 0. Without the macro -> read_count=0 throughout.
